// File: rtl/seq_divider.sv
// Sequential signed 32/32 divider using one restoring shift-subtract step per
// clock. Result packs the remainder in [63:32] and the quotient in [31:0].
// A zero divisor skips the iteration and reports the dividend with an
// all-ones quotient and DivByZero set.
module seq_divider (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [31:0] Dividend,
  input  logic [31:0] Divisor,
  output logic        Busy,
  output logic        Done,
  output logic [63:0] Result,
  output logic        DivByZero
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t      state;
  logic [5:0]  count;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvsr;
  logic        neg_quo;
  logic        neg_rem;
  logic        div_zero;

  logic [32:0] shifted;
  logic [32:0] trial;
  logic        fits;
  logic [31:0] quo_signed;
  logic [31:0] rem_signed;
  logic [31:0] dividend_restored;

  // Unsigned magnitude of a two's-complement word; -2^31 maps to 0x80000000.
  function automatic logic [31:0] magnitude(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // One restoring step: shift the next dividend bit into the partial
  // remainder and attempt a 33-bit subtract. Because the partial remainder is
  // always below the divisor, bit 32 of the trial is set exactly when the
  // subtract borrows. Also forms the sign-corrected outputs for FIX.
  always_comb begin
    shifted           = {rem, quo[31]};
    trial             = shifted - {1'b0, dvsr};
    fits              = ~trial[32];
    quo_signed        = neg_quo ? (~quo + 32'd1) : quo;
    rem_signed        = neg_rem ? (~rem + 32'd1) : rem;
    dividend_restored = neg_rem ? (~quo + 32'd1) : quo;
  end

  // Control FSM and datapath registers; all outputs are registered here.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      count     <= 6'd0;
      rem       <= 32'd0;
      quo       <= 32'd0;
      dvsr      <= 32'd0;
      neg_quo   <= 1'b0;
      neg_rem   <= 1'b0;
      div_zero  <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Result    <= 64'd0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            neg_quo  <= Dividend[31] ^ Divisor[31];
            neg_rem  <= Dividend[31];
            quo      <= magnitude(Dividend);
            dvsr     <= magnitude(Divisor);
            rem      <= 32'd0;
            count    <= 6'd0;
            div_zero <= (Divisor == 32'd0);
            Busy     <= 1'b1;
            state    <= (Divisor == 32'd0) ? FIX : CALC;
          end
        end
        CALC: begin
          rem   <= fits ? trial[31:0] : shifted[31:0];
          quo   <= {quo[30:0], fits};
          count <= count + 6'd1;
          if (count == 6'd31) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (div_zero) begin
            Result <= {dividend_restored, 32'hFFFF_FFFF};
          end else begin
            Result <= {rem_signed, quo_signed};
          end
          DivByZero <= div_zero;
          Done      <= 1'b1;
          Busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed divides with hand-computed
// results and latencies, plus a cycle-by-cycle comparison against an
// arithmetic reference model of the divider's externally visible behaviour.
module tb_seq_divider;

  logic        Clock;
  logic        Resetn;
  logic        Start;
  logic [31:0] Dividend;
  logic [31:0] Divisor;
  logic        Busy;
  logic        Done;
  logic [63:0] Result;
  logic        DivByZero;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic        m_busy      = 1'b0;
  int          edge_no     = 0;
  int          done_edge   = 0;
  logic [63:0] pend_result = 64'd0;
  logic        pend_dz     = 1'b0;
  logic        exp_busy    = 1'b0;
  logic        exp_done    = 1'b0;
  logic [63:0] exp_result  = 64'd0;
  logic        exp_dz      = 1'b0;

  seq_divider dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Busy      (Busy),
    .Done      (Done),
    .Result    (Result),
    .DivByZero (DivByZero)
  );

  // 10-unit clock period
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Arithmetic definition of the divide: {DivByZero, remainder, quotient}
  function automatic logic [64:0] model_div(input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    int q;
    int r;
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {1'b0, 32'(r), 32'(q)};
  endfunction

  // Timing model: a request is taken on any edge where the model is idle and
  // Start is high; its result appears 33 edges later (1 edge for a zero
  // divisor), and the model is idle again from that edge on.
  always @(posedge Clock or negedge Resetn) begin
    logic was_busy;
    if (!Resetn) begin
      m_busy     = 1'b0;
      exp_busy   = 1'b0;
      exp_done   = 1'b0;
      exp_result = 64'd0;
      exp_dz     = 1'b0;
    end else begin
      was_busy = m_busy;
      edge_no  = edge_no + 1;
      exp_done = 1'b0;
      if (m_busy && edge_no == done_edge) begin
        exp_done   = 1'b1;
        exp_result = pend_result;
        exp_dz     = pend_dz;
        m_busy     = 1'b0;
      end
      if (!was_busy && Start) begin
        {pend_dz, pend_result} = model_div(Dividend, Divisor);
        done_edge = edge_no + (pend_dz ? 1 : 33);
        m_busy    = 1'b1;
      end
      exp_busy = m_busy;
    end
  end

  // Every cycle, all DUT outputs must match the model
  always @(negedge Clock) begin
    vectors = vectors + 1;
    if ({Busy, Done, DivByZero, Result} !== {exp_busy, exp_done, exp_dz, exp_result}) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL cycle_outputs at %0t: got busy=%b done=%b dz=%b result=0x%016h, expected busy=%b done=%b dz=%b result=0x%016h",
               $time, Busy, Done, DivByZero, Result, exp_busy, exp_done, exp_dz, exp_result);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] expv);
    vectors = vectors + 1;
    if (got !== expv) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, got, expv);
    end
  endtask

  // Call right after a falling edge: raises Start, scrambles the operands once
  // the request has been taken, optionally re-pulses Start while busy, and
  // checks latency (in falling edges) and the final result.
  task automatic applyStimulus(input logic [31:0] dvd, input logic [31:0] dvs,
                               input logic [63:0] exp_res, input logic exp_dzv,
                               input int exp_lat, input string name, input bit repulse);
    int n;
    Dividend = dvd;
    Divisor  = dvs;
    Start    = 1'b1;
    n        = 0;
    do begin
      @(negedge Clock);
      n        = n + 1;
      Start    = repulse && (n == 5);
      Dividend = $urandom;
      Divisor  = $urandom;
    end while (!Done && n < 60);
    Start = 1'b0;
    checkOutput({name, "_latency"}, 64'(n), 64'(exp_lat));
    checkOutput({name, "_result"}, Result, exp_res);
    checkOutput({name, "_dz"}, {63'd0, DivByZero}, {63'd0, exp_dzv});
  endtask

  task automatic noDoneWindow(input string name, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clock);
      if (Done) pulses = pulses + 1;
    end
    checkOutput(name, 64'(pulses), 64'd0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    Start    = 1'b0;
    Dividend = 32'd0;
    Divisor  = 32'd0;
    Resetn   = 1'b1;
    #2 Resetn = 1'b0;
    #1;
    checkOutput("reset_result", Result, 64'd0);
    checkOutput("reset_flags", {61'd0, Busy, Done, DivByZero}, 64'd0);
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;

    $display("[TB] basic positive divides");
    @(negedge Clock);
    applyStimulus(32'h0000_0014, 32'h0000_0012, 64'h00000002_00000001, 1'b0, 34, "div_20_18", 1'b0);
    @(negedge Clock);
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 64'h00000000_7FFFFFFF, 1'b0, 34, "div_max_1", 1'b0);

    $display("[TB] signed divides");
    @(negedge Clock);
    applyStimulus(32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 34, "div_m7_2", 1'b0);
    @(negedge Clock);
    applyStimulus(32'h0000_0007, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 1'b0, 34, "div_7_m2", 1'b0);

    $display("[TB] divide by zero");
    @(negedge Clock);
    applyStimulus(32'h0000_0012, 32'h0000_0000, 64'h00000012_FFFFFFFF, 1'b1, 2, "div_18_0", 1'b0);

    $display("[TB] overflow case with Start re-pulsed while busy");
    @(negedge Clock);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 1'b0, 34, "div_min_m1", 1'b1);
    noDoneWindow("no_extra_done", 40);
    @(negedge Clock);
    applyStimulus(32'h8000_0000, 32'h0000_0000, 64'h80000000_FFFFFFFF, 1'b1, 2, "div_min_0", 1'b0);

    $display("[TB] reset during a divide");
    @(negedge Clock);
    Dividend = 32'd100;
    Divisor  = 32'd7;
    Start    = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (9) @(negedge Clock);
    #2 Resetn = 1'b0;
    #1;
    checkOutput("abort_result", Result, 64'd0);
    checkOutput("abort_flags", {61'd0, Busy, Done, DivByZero}, 64'd0);
    noDoneWindow("abort_no_done", 5);
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    applyStimulus(32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 34, "div_100_7", 1'b0);

    $display("[TB] back-to-back divides with Start held high");
    @(negedge Clock);
    Dividend = 32'd1000;
    Divisor  = 32'hFFFF_FFDF;
    Start    = 1'b1;
    n = 0;
    do begin
      @(negedge Clock);
      n = n + 1;
    end while (!Done && n < 60);
    checkOutput("b2b_first_latency", 64'(n), 64'd34);
    checkOutput("b2b_first_result", Result, 64'h0000000A_FFFFFFE2);
    Dividend = 32'hFFFF_FC18;
    Divisor  = 32'h0000_0021;
    n = 0;
    do begin
      @(negedge Clock);
      n = n + 1;
      if (n == 1) Start = 1'b0;
    end while (!Done && n < 60);
    Start = 1'b0;
    checkOutput("b2b_second_latency", 64'(n), 64'd34);
    checkOutput("b2b_second_result", Result, 64'hFFFFFFF6_FFFFFFE2);

    repeat (3) @(negedge Clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
